// File: rtl/current_filter_scheduler.sv
// -----------------------------------------------------------------------------
// current_filter_scheduler
//
// Frame scheduler in front of the shared multichannel current FIR filter.
// Per-channel ADC strobes arrive at any time. They are latched into sample
// registers and aligned to an internal frame counter. Once per frame the
// packed sample vector goes to the filter over valid/ready. The filtered
// vector is then captured and shown to the current loop as a one-cycle
// out_valid pulse.
//
// Optional feature macro: CURRENT_SCHED_STATS_EN
//   defined   -> overrun_count / missing_count saturating statistics are built
//   undefined -> both statistics ports are tied to 0 (frame dropping and
//                out_missing are unaffected)
//
// Ports
//   clk, reset       clock; asynchronous active-high reset
//   enable           run the frame counter (0 holds it at 0)
//   adc_data         {ch0,ch1,...}, ch0 in the MSB slice
//   adc_strobe       bit i pulses when channel i of adc_data is valid
//   flt_in_*         packed vector handshake towards the filter
//   flt_out_*        filtered vector handshake from the filter
//   out_data         filtered vector, held until the next out_valid
//   out_valid        one-cycle pulse when out_data updates
//   out_missing      channels that had no strobe in out_data's frame
//   overrun_count    saturating count of dropped frames
//   missing_count    saturating count of missing channel-samples
// -----------------------------------------------------------------------------
module current_filter_scheduler #(
    parameter int DATA_WIDTH   = 16,
    parameter int CHANNELS     = 3,
    parameter int FRAME_CYCLES = 2000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [CHANNELS*DATA_WIDTH-1:0] adc_data,
    input  logic [CHANNELS-1:0]            adc_strobe,
    output logic [CHANNELS*DATA_WIDTH-1:0] flt_in_data,
    output logic                           flt_in_valid,
    input  logic                           flt_in_ready,
    input  logic [CHANNELS*DATA_WIDTH-1:0] flt_out_data,
    input  logic                           flt_out_valid,
    output logic                           flt_out_ready,
    output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
    output logic                           out_valid,
    output logic [CHANNELS-1:0]            out_missing,
    output logic [7:0]                     overrun_count,
    output logic [15:0]                    missing_count
);

    localparam int VW = CHANNELS * DATA_WIDTH;
    localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_CYCLES - 1);

    generate
        if (FRAME_CYCLES < 4) begin : g_bad_frame
            $error("current_filter_scheduler: FRAME_CYCLES must be >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_COLLECT  = 2'd0,
        S_DISPATCH = 2'd1,
        S_WAIT     = 2'd2
    } state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic                    frame_end;
    logic                    dispatch_fire;
    logic [DATA_WIDTH-1:0]   sample [CHANNELS];
    logic [CHANNELS-1:0]     got;
    logic [CHANNELS-1:0]     miss;
    logic [CHANNELS-1:0]     miss_now;
    logic [VW-1:0]           dispatch_vec;

    assign frame_end     = enable && (cnt == LAST_CNT);
    assign dispatch_fire = frame_end && (state == S_COLLECT);

    // A strobe on the frame_end cycle still belongs to the ending frame,
    // so it counts as "got" and its value bypasses the sample register.
    assign miss_now = ~(got | adc_strobe);

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            localparam int LO = (CHANNELS - 1 - gi) * DATA_WIDTH;
            assign dispatch_vec[LO +: DATA_WIDTH] =
                adc_strobe[gi] ? adc_data[LO +: DATA_WIDTH] : sample[gi];
        end
    endgenerate

    // Frame counter: free-running 0..FRAME_CYCLES-1 while enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!enable) begin
            cnt <= '0;
        end else if (cnt == LAST_CNT) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Sample capture runs in every state. got[] is cleared on every
    // frame_end, including dropped (overrun) frames, so a strobe on the
    // frame_end cycle is consumed by the ending frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                sample[i] <= '0;
            end
            got <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (adc_strobe[i]) begin
                    sample[i] <= adc_data[(CHANNELS-1-i)*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            got <= frame_end ? '0 : (got | adc_strobe);
        end
    end

    // Dispatch / capture FSM with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_COLLECT;
            flt_in_data  <= '0;
            flt_in_valid <= 1'b0;
            miss         <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            out_missing  <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_COLLECT: begin
                    if (frame_end) begin
                        flt_in_data  <= dispatch_vec;
                        miss         <= miss_now;
                        flt_in_valid <= 1'b1;
                        state        <= S_DISPATCH;
                    end
                end
                S_DISPATCH: begin
                    if (flt_in_ready) begin
                        flt_in_valid <= 1'b0;
                        state        <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flt_out_valid) begin
                        out_data    <= flt_out_data;
                        out_missing <= miss;
                        out_valid   <= 1'b1;
                        state       <= S_COLLECT;
                    end
                end
                default: begin
                    flt_in_valid <= 1'b0;
                    state        <= S_COLLECT;
                end
            endcase
        end
    end

    // Pure state decode; the only output with no register in front of it.
    assign flt_out_ready = (state == S_WAIT);

`ifdef CURRENT_SCHED_STATS_EN
    logic        overrun_fire;
    logic [15:0] miss_pop;
    logic [16:0] missing_sum;

    // frame_end while a transaction is still in flight drops that frame.
    assign overrun_fire = frame_end && (state != S_COLLECT);

    always_comb begin
        miss_pop = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            miss_pop = miss_pop + 16'(miss_now[i]);
        end
    end

    assign missing_sum = {1'b0, missing_count} + {1'b0, miss_pop};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_count <= '0;
            missing_count <= '0;
        end else begin
            if (overrun_fire && (overrun_count != 8'hFF)) begin
                overrun_count <= overrun_count + 8'd1;
            end
            if (dispatch_fire) begin
                missing_count <= missing_sum[16] ? 16'hFFFF : missing_sum[15:0];
            end
        end
    end
`else
    assign overrun_count = '0;
    assign missing_count = '0;
`endif

endmodule

// File: tb/tb_current_filter_scheduler.sv
// -----------------------------------------------------------------------------
// tb_current_filter_scheduler
//
// Directed bench for current_filter_scheduler with CHANNELS=3,
// FRAME_CYCLES=20, DATA_WIDTH=16. A small behavioural filter model accepts
// one vector, waits two cycles and returns every channel incremented by one.
// The local counter cyc follows the DUT frame counter: cycle c is the cycle in
// which the counter holds c mod 20, so frame_end falls on cycles 19, 39, ...
// -----------------------------------------------------------------------------
module tb_current_filter_scheduler;

    localparam int W  = 16;
    localparam int C  = 3;
    localparam int FC = 20;
    localparam int VW = C * W;

`ifdef CURRENT_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [VW-1:0] adc_data;
    logic [C-1:0]  adc_strobe;
    logic [VW-1:0] flt_in_data;
    logic          flt_in_valid;
    logic          flt_in_ready;
    logic [VW-1:0] flt_out_data;
    logic          flt_out_valid;
    logic          flt_out_ready;
    logic [VW-1:0] out_data;
    logic          out_valid;
    logic [C-1:0]  out_missing;
    logic [7:0]    overrun_count;
    logic [15:0]   missing_count;

    always #5 clk = ~clk;

    current_filter_scheduler #(
        .DATA_WIDTH  (W),
        .CHANNELS    (C),
        .FRAME_CYCLES(FC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .adc_data     (adc_data),
        .adc_strobe   (adc_strobe),
        .flt_in_data  (flt_in_data),
        .flt_in_valid (flt_in_valid),
        .flt_in_ready (flt_in_ready),
        .flt_out_data (flt_out_data),
        .flt_out_valid(flt_out_valid),
        .flt_out_ready(flt_out_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_missing  (out_missing),
        .overrun_count(overrun_count),
        .missing_count(missing_count)
    );

    // ---------------- behavioural filter model ----------------
    logic          hold_ready;
    logic          pend;
    logic [1:0]    dly;
    logic [VW-1:0] mdata;

    function automatic logic [VW-1:0] plus1(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        for (int i = 0; i < C; i++) begin
            r[i*W +: W] = v[i*W +: W] + 16'd1;
        end
        return r;
    endfunction

    assign flt_in_ready  = !hold_ready && !pend;
    assign flt_out_valid = pend && (dly == 2'd0);
    assign flt_out_data  = mdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend  <= 1'b0;
            dly   <= 2'd0;
            mdata <= '0;
        end else if (flt_in_valid && flt_in_ready) begin
            pend  <= 1'b1;
            dly   <= 2'd2;
            mdata <= plus1(flt_in_data);
        end else if (pend) begin
            if (flt_out_valid && flt_out_ready) begin
                pend <= 1'b0;
            end else if (dly != 2'd0) begin
                dly <= dly - 2'd1;
            end
        end
    end

    // One line per transaction.
    always @(negedge clk) begin
        if (flt_in_valid && flt_in_ready)
            $display("dispatch: in_data=%h", flt_in_data);
        if (out_valid)
            $display("result:   out_data=%h missing=%b", out_data, out_missing);
    end

    // ---------------- checking helpers ----------------
    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [VW-1:0] pack3(input int a, input int b, input int c);
        return {a[15:0], b[15:0], c[15:0]};
    endfunction

    function automatic logic [15:0] st(input int v);
        return STATS ? v[15:0] : 16'd0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic go_to(input int n);
        while (cyc < n) step();
    endtask

    // Strobe channel ch with value v during cycle c.
    task automatic strobe_at(input int c, input int ch, input int v);
        go_to(c);
        adc_data[(C-1-ch)*W +: W] = v[15:0];
        adc_strobe[ch] = 1'b1;
        step();
        adc_strobe = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_data"},      out_data, '0);
        check({tag, "_out_valid"},     out_valid, '0);
        check({tag, "_out_missing"},   out_missing, '0);
        check({tag, "_flt_in_valid"},  flt_in_valid, '0);
        check({tag, "_flt_in_data"},   flt_in_data, '0);
        check({tag, "_flt_out_ready"}, flt_out_ready, '0);
        check({tag, "_overrun"},       overrun_count, '0);
        check({tag, "_missing"},       missing_count, '0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        adc_data   = '0;
        adc_strobe = '0;
        hold_ready = 1'b0;
        repeat (3) step();
        check_all_zero("reset");

        reset  = 1'b0;
        enable = 1'b1;
        cyc    = 0;

        // Frame 1: all three channels strobed.
        strobe_at(3, 0, 100);
        strobe_at(4, 1, 200);
        strobe_at(5, 2, -300);
        go_to(19);
        check("f1_valid_before_fe", flt_in_valid, 1'b0);
        check("f1_out_ready_collect", flt_out_ready, 1'b0);
        go_to(20);
        check("f1_in_valid", flt_in_valid, 1'b1);
        check("f1_in_data", flt_in_data, pack3(100, 200, -300));
        go_to(22);
        check("f1_in_valid_dropped", flt_in_valid, 1'b0);
        check("f1_out_ready_wait", flt_out_ready, 1'b1);
        go_to(24);
        check("f1_out_valid", out_valid, 1'b1);
        check("f1_out_data", out_data, pack3(101, 201, -299));
        check("f1_out_missing", out_missing, 3'b000);
        go_to(25);
        check("f1_out_valid_pulse", out_valid, 1'b0);
        check("f1_out_data_held", out_data, pack3(101, 201, -299));

        // Frame 2: ch1 missing, resends 200.
        strobe_at(25, 0, 111);
        strobe_at(26, 2, -222);
        go_to(40);
        check("f2_in_data", flt_in_data, pack3(111, 200, -222));
        check("f2_missing_count", missing_count, st(1));
        go_to(44);
        check("f2_out_valid", out_valid, 1'b1);
        check("f2_out_data", out_data, pack3(112, 201, -221));
        check("f2_out_missing", out_missing, 3'b010);

        // Frame 3: ch2 strobed on frame_end, then again on frame_end+1.
        strobe_at(45, 0, 7);
        strobe_at(46, 1, 8);
        strobe_at(59, 2, -5);
        check("f3_in_data_fe_strobe", flt_in_data, pack3(7, 8, -5));
        strobe_at(60, 2, -6);
        go_to(64);
        check("f3_out_data", out_data, pack3(8, 9, -4));
        check("f3_out_missing", out_missing, 3'b000);
        check("f3_missing_count", missing_count, st(1));

        // Frame 4: the frame_end+1 strobe lands here.
        strobe_at(61, 0, 9);
        strobe_at(62, 1, 10);
        go_to(80);
        check("f4_in_data_next_frame", flt_in_data, pack3(9, 10, -6));
        go_to(84);
        check("f4_out_missing", out_missing, 3'b000);

        // Frame 5 dispatch stalls for 25 cycles; frame 6 is dropped.
        strobe_at(85, 0, 1);
        strobe_at(86, 1, 2);
        strobe_at(87, 2, 3);
        go_to(99);
        hold_ready = 1'b1;
        for (int k = 100; k < 125; k++) begin
            go_to(k);
            if (k == 110) begin
                adc_data[(C-2)*W +: W] = 16'd50;
                adc_strobe = 3'b010;
            end else begin
                adc_strobe = '0;
            end
            check($sformatf("stall_valid_c%0d", k), flt_in_valid, 1'b1);
            check($sformatf("stall_data_c%0d", k), flt_in_data, pack3(1, 2, 3));
        end
        check("overrun_count", overrun_count, {8'd0, st(1)} >> 8 == 0 ? st(1) : 16'd0);
        go_to(125);
        hold_ready = 1'b0;
        go_to(129);
        check("f5_out_valid", out_valid, 1'b1);
        check("f5_out_data", out_data, pack3(2, 3, 4));

        // Frame 7: got[] was cleared by the dropped frame, so all missing.
        go_to(140);
        check("f7_in_data", flt_in_data, pack3(1, 50, 3));
        check("f7_missing_count", missing_count, st(4));
        check("f7_overrun_hold", overrun_count, st(1));
        go_to(144);
        check("f7_out_data", out_data, pack3(2, 51, 4));
        check("f7_out_missing", out_missing, 3'b111);

        // Frame 8: reset while waiting for the filter result.
        strobe_at(145, 0, 77);
        go_to(160);
        check("f8_in_data", flt_in_data, pack3(77, 50, 3));
        go_to(162);
        check("f8_in_wait", flt_out_ready, 1'b1);
        reset  = 1'b1;
        enable = 1'b0;
        #1;
        check_all_zero("midreset");
        step();
        step();
        reset  = 1'b0;
        enable = 1'b1;
        cyc    = 0;

        // First frame after reset: unstrobed channels send 0.
        strobe_at(5, 1, 42);
        go_to(19);
        check("r1_no_stale_out", out_valid, 1'b0);
        go_to(20);
        check("r1_in_valid", flt_in_valid, 1'b1);
        check("r1_in_data", flt_in_data, pack3(0, 42, 0));
        check("r1_missing_count", missing_count, st(2));
        go_to(24);
        check("r1_out_valid", out_valid, 1'b1);
        check("r1_out_data", out_data, pack3(1, 43, 1));
        check("r1_out_missing", out_missing, 3'b101);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
